// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_ctrl
// Purpose  : Byte-transfer controller that sits between TX/RX FIFOs and an
//            SPI master. Optional watchdog enabled by SPI_XFER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_m_start,
  output logic [7:0] o_m_dout,
  input  logic [7:0] i_m_din,
  input  logic       i_m_cs,
  output logic       o_busy,
  output logic       o_err,
  input  logic       i_err_clr
);

  localparam int             c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_ptr_one = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_CAPT    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_m_start;
  logic [7:0]    r_m_dout;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [c_aw:0] r_tx_wr, r_tx_rd;
  logic [7:0]    r_rx_mem [DEPTH];
  logic [c_aw:0] r_rx_wr, r_rx_rd;

  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
  logic w_in_wait;

  // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[c_aw] != r_tx_rd[c_aw]) &&
                      (r_tx_wr[c_aw-1:0] == r_tx_rd[c_aw-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[c_aw] != r_rx_rd[c_aw]) &&
                      (r_rx_wr[c_aw-1:0] == r_rx_rd[c_aw-1:0]);

  assign w_tx_push  = i_tx_valid && !w_tx_full;
  assign w_rx_pop   = i_rx_ready && !w_rx_empty;
  assign w_in_wait  = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);

  assign o_tx_ready = !w_tx_full;
  assign o_rx_valid = !w_rx_empty;
  assign o_rx_data  = r_rx_mem[r_rx_rd[c_aw-1:0]];
  assign o_m_start  = r_m_start;
  assign o_m_dout   = r_m_dout;
  assign o_busy     = (r_state != S_IDLE) || !w_tx_empty;

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int              c_tw      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tmo_max = c_tw'(TIMEOUT);
  localparam logic [c_tw-1:0] c_tmo_one = 1;

  logic [c_tw-1:0] r_tmo_cnt;
  logic            r_err;
  logic            w_tmo_hit;

  // Counter restarts on every state change so each wait state gets a full budget.
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state) || !w_in_wait) r_tmo_cnt <= '0;
    else                                          r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
  end

  always_ff @(posedge clk) begin
    if (rst)            r_err <= 1'b0;
    else if (w_tmo_hit) r_err <= 1'b1;
    else if (i_err_clr) r_err <= 1'b0;
  end

  assign o_err = r_err;
`else
  localparam int c_unused_timeout = TIMEOUT;
  logic w_unused_err_clr;
  assign w_unused_err_clr = i_err_clr;
  assign o_err = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_tx_pop  = 1'b0;
    w_rx_push = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
    w_tmo_hit = 1'b0;
`endif
    case (r_state)
      S_IDLE:    if (!w_tx_empty && !w_rx_full) w_next = S_LAUNCH;
      S_LAUNCH:  begin w_tx_pop = 1'b1; w_next = S_WAIT_LO; end
      S_WAIT_LO: if (!i_m_cs) w_next = S_WAIT_HI;
      S_WAIT_HI: if (i_m_cs)  w_next = S_CAPT;
      S_CAPT:    begin w_rx_push = 1'b1; w_next = S_IDLE; end
      default:   w_next = S_IDLE;
    endcase
`ifdef SPI_XFER_TIMEOUT_EN
    if (w_in_wait && (r_tmo_cnt == c_tmo_max)) begin
      w_next    = S_IDLE;
      w_tmo_hit = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m_start <= 1'b0;
      r_m_dout  <= 8'h00;
    end else begin
      r_state   <= w_next;
      r_m_start <= (r_state == S_LAUNCH);
      if (r_state == S_LAUNCH) r_m_dout <= r_tx_mem[r_tx_rd[c_aw-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_ptr_one;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_ptr_one;
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_ptr_one;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[c_aw-1:0]] <= i_tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[c_aw-1:0]] <= i_m_din;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_ctrl
// Purpose  : Directed self-checking bench for spi_xfer_ctrl with an SPI
//            master model that answers each byte with (byte + 0xDE).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 63;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       m_start;
  logic [7:0] m_dout;
  logic [7:0] m_din;
  logic       m_cs;
  logic       busy;
  logic       err;
  logic       err_clr = 1'b0;

  logic       model_en = 1'b1;
  logic       mdl_cs = 1'b1;
  logic [7:0] mdl_din = 8'h00;
  logic       man_cs = 1'b1;
  logic [7:0] man_din = 8'hAA;
  logic [7:0] lat_dout;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  logic [7:0] launch_q[$];
  int         start_cyc[$];
  logic [7:0] rx_q[$];
  logic       txr_low_seen = 1'b0;

  assign m_cs  = model_en ? mdl_cs  : man_cs;
  assign m_din = model_en ? mdl_din : man_din;

  spi_xfer_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .i_rx_ready (rx_ready),
    .o_m_start  (m_start),
    .o_m_dout   (m_dout),
    .i_m_din    (m_din),
    .i_m_cs     (m_cs),
    .o_busy     (busy),
    .o_err      (err),
    .i_err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Monitors read pre-edge values at the rising edge.
  always @(posedge clk) begin
    if (!rst && m_start === 1'b1) begin
      launch_q.push_back(m_dout);
      start_cyc.push_back(cyc);
    end
    if (!rst && rx_valid === 1'b1 && rx_ready === 1'b1) rx_q.push_back(rx_data);
    if (!rst && tx_ready !== 1'b1) txr_low_seen = 1'b1;
    cyc++;
  end

  // SPI master model: CS low one cycle after START, high three cycles later.
  always begin
    @(posedge clk);
    if (model_en && m_start === 1'b1) begin
      lat_dout = m_dout;
      @(posedge clk); #1 mdl_cs = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mdl_din = lat_dout + 8'hDE;
      mdl_cs  = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d);
    int   n = 0;
    logic acc;
    tx_data  = d;
    tx_valid = 1'b1;
    do begin
      acc = tx_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    tx_valid = 1'b0;
    check("push_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_start(input int lim);
    int n = 0;
    while (m_start !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    check("start_seen", {31'd0, m_start}, 32'd1);
  endtask

  task automatic clear_q();
    launch_q.delete(); start_cyc.delete(); rx_q.delete();
    txr_low_seen = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_m_start",  {31'd0, m_start},  32'd0);
    check("rst_m_dout",   {24'd0, m_dout},   32'h00);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0x56 -> 0x34, exact launch latency
    clear_q();
    tx_data = 8'h56; tx_valid = 1'b1;
    @(negedge clk);                     // edge k accepted the byte
    tx_valid = 1'b0;
    check("t1_busy_after_push", {31'd0, busy},    32'd1);
    check("t1_start_k0",        {31'd0, m_start}, 32'd0);
    @(negedge clk);
    check("t1_start_k1",        {31'd0, m_start}, 32'd0);
    @(negedge clk);
    check("t1_start_k2",        {31'd0, m_start}, 32'd1);
    check("t1_dout",            {24'd0, m_dout},  32'h56);
    @(negedge clk);
    check("t1_start_k3",        {31'd0, m_start}, 32'd0);
    check("t1_dout_hold",       {24'd0, m_dout},  32'h56);
    n = 0;
    while (rx_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t1_rx_valid",        {31'd0, rx_valid}, 32'd1);
    check("t1_rx_data",         {24'd0, rx_data},  32'h34);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("t1_rx_empty",        {31'd0, rx_valid}, 32'd0);
    check("t1_busy_done",       {31'd0, busy},     32'd0);
    check("t1_launch_cnt",      launch_q.size(),   32'd1);

    // Back-to-back 0x01..0x04
    clear_q();
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    n = 0;
    while (rx_q.size() < 4 && n < 200) begin @(negedge clk); n++; end
    check("t2_rx_cnt",     rx_q.size(),     32'd4);
    check("t2_launch_cnt", launch_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < launch_q.size() && i < rx_q.size(); i++) begin
      check("t2_launch_order", {24'd0, launch_q[i]}, 32'(i + 1));
      check("t2_rx_order",     {24'd0, rx_q[i]},     32'(8'(i + 1) + 8'hDE));
    end
    for (int i = 0; i + 1 < start_cyc.size(); i++)
      check("t2_start_period", 32'(start_cyc[i+1] - start_cyc[i]), 32'd9);
    check("t2_tx_ready_high", {31'd0, txr_low_seen}, 32'd0);
    @(negedge clk);
    check("t2_busy_done", {31'd0, busy}, 32'd0);

    // RX back-pressure: five bytes into a four-deep RX FIFO
    clear_q();
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    repeat (80) @(negedge clk);
    check("t3_stall_launches", launch_q.size(), 32'd4);
    check("t3_stall_busy",     {31'd0, busy},     32'd1);
    check("t3_stall_rx_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    n = 0;
    while (rx_q.size() < 5 && n < 200) begin @(negedge clk); n++; end
    check("t3_launch_cnt", launch_q.size(), 32'd5);
    check("t3_rx_cnt",     rx_q.size(),     32'd5);
    if (launch_q.size() == 5 && rx_q.size() == 5) begin
      check("t3_launch5", {24'd0, launch_q[4]}, 32'h14);
      check("t3_rx0",     {24'd0, rx_q[0]},     32'hEE);
      check("t3_rx4",     {24'd0, rx_q[4]},     32'hF2);
    end
    @(negedge clk);
    check("t3_busy_done", {31'd0, busy}, 32'd0);

    // Reset while waiting for CS to return high
    clear_q();
    model_en = 1'b0;
    man_cs   = 1'b1;
    push(8'h77);
    wait_start(20);
    man_cs = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t4_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("t4_m_start",  {31'd0, m_start},  32'd0);
    check("t4_m_dout",   {24'd0, m_dout},   32'h00);
    check("t4_busy",     {31'd0, busy},     32'd0);
    check("t4_err",      {31'd0, err},      32'd0);
    man_cs = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_no_rx_after_cs", {31'd0, rx_valid}, 32'd0);
    check("t4_busy_after_cs",  {31'd0, busy},     32'd0);

`ifdef SPI_XFER_TIMEOUT_EN
    // Watchdog: CS never goes low
    push(8'h99);
    wait_start(20);
    repeat (TIMEOUT) @(negedge clk);
    check("t5_err_before", {31'd0, err},  32'd0);
    check("t5_busy_wait",  {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t5_err_set",    {31'd0, err},      32'd1);
    check("t5_no_rx",      {31'd0, rx_valid}, 32'd0);
    check("t5_busy_idle",  {31'd0, busy},     32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_err_clr",    {31'd0, err}, 32'd0);
    push(8'h9A);
    wait_start(20);
    repeat (TIMEOUT) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_set_wins",   {31'd0, err},      32'd1);
    check("t5_no_rx2",     {31'd0, rx_valid}, 32'd0);
`else
    // Without the watchdog a stuck transfer waits indefinitely
    push(8'h99);
    wait_start(20);
    repeat (100) @(negedge clk);
    check("t5_still_busy", {31'd0, busy},     32'd1);
    check("t5_err_zero",   {31'd0, err},      32'd0);
    check("t5_no_rx",      {31'd0, rx_valid}, 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_err",  {31'd0, err},  32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: entries in each of the TX and RX FIFOs; power of two, minimum 2.
REQ-002 Parameter TIMEOUT, default 63: watchdog limit in CLK cycles; used only when SPI_XFER_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  system clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 TX_DATA  in  8  byte to send.
REQ-006 TX_VALID  in  1  TX_DATA is valid.
REQ-007 TX_READY  out  1  TX FIFO can accept a byte.
REQ-008 RX_DATA  out  8  oldest received byte.
REQ-009 RX_VALID  out  1  RX FIFO is non-empty.
REQ-010 RX_READY  in  1  consumer takes RX_DATA.
REQ-011 M_START  out  1  one-cycle start pulse to the SPI master's START input.
REQ-012 M_DOUT  out  8  byte to the SPI master's DOUT input.
REQ-013 M_DIN  in  8  the SPI master's DIN output, i.e. the byte captured from MISO.
REQ-014 M_CS  in  1  the SPI master's CS output; low while a transfer is in progress.
REQ-015 BUSY  out  1  a transfer is pending or in flight.
REQ-016 ERR  out  1  sticky transfer-timeout flag.
REQ-017 ERR_CLR  in  1  clears ERR.

Function
REQ-018 The TX FIFO pushes on TX_VALID&TX_READY; TX_READY = not full; a pop in the same cycle does not raise TX_READY while the FIFO is full.
REQ-019 The RX FIFO is first-word-fall-through: RX_DATA = head, RX_VALID = not empty, pop on RX_VALID&RX_READY.
REQ-020 FSM states: IDLE, LAUNCH, WAIT_LO, WAIT_HI, CAPT.
REQ-021 IDLE -> LAUNCH when the TX FIFO is non-empty and the RX FIFO is not full; otherwise remain in IDLE, with no byte ever dropped.
REQ-022 LAUNCH: load M_DOUT from the TX head, pop the TX FIFO, assert M_START for exactly one cycle, then go to WAIT_LO.
REQ-023 For a byte accepted into an empty, idle block at edge k, M_START is high during the cycle after edge k+2.
REQ-024 WAIT_LO -> WAIT_HI when M_CS is sampled 0.
REQ-025 WAIT_HI -> CAPT when M_CS is sampled 1.
REQ-026 CAPT: push M_DIN into the RX FIFO, then return to IDLE; RX_VALID rises the cycle after CAPT.
REQ-027 M_DOUT holds its value between launches.
REQ-028 BUSY = (state != IDLE) | TX FIFO non-empty.
REQ-029 Back-to-back bytes launch in order with exactly one IDLE cycle between CAPT and the next LAUNCH.
REQ-030 Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-031 When ERR_CLR coincides with a new error, the set wins.

Reset
REQ-032 On RST: FSM to IDLE, both FIFOs flushed; M_START=0, M_DOUT=0, RX_VALID=0, TX_READY=1, BUSY=0, ERR=0.
REQ-033 RST during WAIT_LO or WAIT_HI abandons the transfer; the later M_CS return is ignored and nothing is pushed to RX.

Configuration
REQ-034 With SPI_XFER_TIMEOUT_EN defined, a counter runs in WAIT_LO and WAIT_HI, clearing on each state entry.
REQ-035 With SPI_XFER_TIMEOUT_EN defined, once the counter reaches TIMEOUT the FSM returns to IDLE, pushes nothing to RX, and sets ERR.
REQ-036 Without SPI_XFER_TIMEOUT_EN, the wait states wait indefinitely and ERR is tied to 0.

Verification
REQ-037 Push 0x56 with a master model that returns 0x34 -> one M_START pulse, M_DOUT=0x56, then RX_DATA=0x34 with RX_VALID=1, then BUSY=0.
REQ-038 Push 0x01..0x04 back-to-back with RX_READY=1 -> four launches in order, RX order matches the returned bytes, TX_READY stays high throughout.
REQ-039 RX_READY=0 and 5 bytes pushed (DEPTH=4) -> exactly 4 transfers, then the FSM stalls in IDLE with BUSY=1; raising RX_READY resumes the fifth transfer.
REQ-040 Assert RST for one cycle while in WAIT_HI -> all outputs take reset values; the subsequent M_CS rise produces no RX_VALID.
REQ-041 SPI_XFER_TIMEOUT_EN defined, M_CS held high after M_START -> ERR=1 after TIMEOUT cycles with no RX push; ERR_CLR clears it; ERR_CLR coincident with a new timeout leaves ERR=1.
